chnlnk_frame_builder: RTL and testbench

Channel-link output stage directly downstream of the channel-link frame-sequencing FSM. It takes that FSM's HDR/VALID/LAST_WRD/CLR_CRC/SEQ strobes and the sample-FIFO read data, and assembles transmit words: header, data words, then a CRC-16 trailer. Between frames it emits comma idles. Its output drives the GTX transmitter user interface.

---
 rtl/chnlnk_pkg.sv | 34 +++
 rtl/chnlnk_crc16.sv | 26 ++
 rtl/chnlnk_frame_builder.sv | 130 +++++++++++++
 tb/tb_chnlnk_frame_builder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/chnlnk_pkg.sv
// Shared types and constants for the channel-link frame builder.
// Latency: none (declarations only).
// Backpressure: none.
package chnlnk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        CRC  = 2'd2
    } state_t;

    localparam logic [15:0] IDLE_WRD = 16'h50BC;   // K28.5 in the low byte
    localparam logic [3:0]  HDR_TAG  = 4'hA;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'h1021;   // CCITT

    // Header field positions: {tag, 5'b0, seq}
    localparam int HDR_TAG_MSB = 15;
    localparam int HDR_TAG_LSB = 12;
    localparam int HDR_SEQ_MSB = 6;
    localparam int HDR_SEQ_LSB = 0;

    localparam logic [1:0] TXK_IDLE = 2'b01;       // comma in low byte
    localparam logic [1:0] TXK_DATA = 2'b00;

    function automatic logic [15:0] mk_hdr(input logic [3:0] tag, input logic [6:0] seq);
        logic [15:0] h;
        h = '0;
        h[HDR_TAG_MSB:HDR_TAG_LSB] = tag;
        h[HDR_SEQ_MSB:HDR_SEQ_LSB] = seq;
        return h;
    endfunction

endpackage

// File: rtl/chnlnk_crc16.sv
// Next-state CRC-16/CCITT over one 16-bit word, MSB first, no reflection.
// Latency: combinational.
// Backpressure: none.
module chnlnk_crc16
    import chnlnk_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [15:0] data,
    output logic [15:0] crc_out
);

    // Sixteen serial LFSR steps, unrolled by the loop into one XOR network.
    always_comb begin
        logic [15:0] c;
        c = crc_in;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ data[i]) begin
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/chnlnk_frame_builder.sv
// Assembles header / data / CRC-16 trailer transmit words, comma idles between frames.
// Latency: one cycle from input strobe to TXD; CRC word two cycles after LAST_WRD.
// Backpressure: none; misplaced strobes are dropped and flagged on sticky PROTO_ERR.
module chnlnk_frame_builder #(
    parameter logic [15:0] IDLE_WRD = chnlnk_pkg::IDLE_WRD,
    parameter logic [3:0]  HDR_TAG  = chnlnk_pkg::HDR_TAG,
    parameter logic [15:0] CRC_INIT = chnlnk_pkg::CRC_INIT
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        HDR,
    input  logic        VALID,
    input  logic        LAST_WRD,
    input  logic        CLR_CRC,
    input  logic [6:0]  SEQ,
    input  logic [15:0] DIN,
    output logic [15:0] TXD,
    output logic [1:0]  TXK,
    output logic        TX_VLD,
    output logic [15:0] FRM_CNT,
    output logic        PROTO_ERR
);
    import chnlnk_pkg::*;

    state_t      state_q, state_d;
    logic [15:0] crc_q, crc_d;
    logic [15:0] txd_q, txd_d;
    logic [1:0]  txk_q, txk_d;
    logic        tx_vld_q, tx_vld_d;
    logic [15:0] frm_cnt_q, frm_cnt_d;
    logic        proto_err_q, proto_err_d;

    logic [15:0] hdr_wrd;
    logic [15:0] crc_base;
    logic [15:0] crc_word_in;
    logic [15:0] crc_next;

    assign hdr_wrd     = mk_hdr(HDR_TAG, SEQ);
    // CLR_CRC reseeds before any word folded in the same cycle.
    assign crc_base    = CLR_CRC ? CRC_INIT : crc_q;
    // Only a header can be absorbed from IDLE; elsewhere the word is DIN.
    assign crc_word_in = (state_q == IDLE) ? hdr_wrd : DIN;

    chnlnk_crc16 u_crc16 (
        .crc_in  (crc_base),
        .data    (crc_word_in),
        .crc_out (crc_next)
    );

    // Next-state, next-CRC and next-output selection.
    always_comb begin
        state_d     = state_q;
        crc_d       = crc_base;
        txd_d       = IDLE_WRD;
        txk_d       = TXK_IDLE;
        tx_vld_d    = 1'b0;
        frm_cnt_d   = frm_cnt_q;
        proto_err_d = proto_err_q;
        case (state_q)
            IDLE: begin
                if (HDR) begin
                    state_d  = BODY;
                    txd_d    = hdr_wrd;
                    txk_d    = TXK_DATA;
                    tx_vld_d = 1'b1;
                    crc_d    = crc_next;
                end
                // data with no open frame; with HDR the header still wins
                if (VALID) begin
                    proto_err_d = 1'b1;
                end
            end
            BODY: begin
                if (HDR) begin
                    // nested header: drop it (and any data beside it), keep the frame
                    proto_err_d = 1'b1;
                end else if (VALID) begin
                    txd_d    = DIN;
                    txk_d    = TXK_DATA;
                    tx_vld_d = 1'b1;
                    crc_d    = crc_next;
                    if (LAST_WRD) begin
                        state_d = CRC;
                    end
                end
            end
            CRC: begin
                txd_d     = crc_q;
                txk_d     = TXK_DATA;
                tx_vld_d  = 1'b1;
                frm_cnt_d = frm_cnt_q + 16'd1;
                state_d   = IDLE;
                if (HDR || VALID) begin
                    proto_err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and outputs registered; reset aborts any frame in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            crc_q       <= CRC_INIT;
            txd_q       <= IDLE_WRD;
            txk_q       <= TXK_IDLE;
            tx_vld_q    <= 1'b0;
            frm_cnt_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            txd_q       <= txd_d;
            txk_q       <= txk_d;
            tx_vld_q    <= tx_vld_d;
            frm_cnt_q   <= frm_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign TXD       = txd_q;
    assign TXK       = txk_q;
    assign TX_VLD    = tx_vld_q;
    assign FRM_CNT   = frm_cnt_q;
    assign PROTO_ERR = proto_err_q;

endmodule

// File: tb/tb_chnlnk_frame_builder.sv
// Directed table-driven bench for chnlnk_frame_builder.
// Latency: each vector's response is checked one clock after it is applied.
// Backpressure: none.
module tb_chnlnk_frame_builder;

    localparam logic [15:0] IDLE_W = 16'h50BC;
    localparam logic [15:0] INIT_W = 16'hFFFF;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        HDR = 1'b0;
    logic        VALID = 1'b0;
    logic        LAST_WRD = 1'b0;
    logic        CLR_CRC = 1'b0;
    logic [6:0]  SEQ = '0;
    logic [15:0] DIN = '0;
    logic [15:0] TXD;
    logic [1:0]  TXK;
    logic        TX_VLD;
    logic [15:0] FRM_CNT;
    logic        PROTO_ERR;

    always #5 CLK = ~CLK;

    chnlnk_frame_builder #(
        .IDLE_WRD (16'h50BC),
        .HDR_TAG  (4'hA),
        .CRC_INIT (16'hFFFF)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .HDR       (HDR),
        .VALID     (VALID),
        .LAST_WRD  (LAST_WRD),
        .CLR_CRC   (CLR_CRC),
        .SEQ       (SEQ),
        .DIN       (DIN),
        .TXD       (TXD),
        .TXK       (TXK),
        .TX_VLD    (TX_VLD),
        .FRM_CNT   (FRM_CNT),
        .PROTO_ERR (PROTO_ERR)
    );

    typedef struct {
        logic        hdr;
        logic        valid;
        logic        last;
        logic        clr;
        logic [6:0]  seq;
        logic [15:0] din;
        logic [15:0] e_txd;
        logic [1:0]  e_txk;
        logic        e_vld;
        logic [15:0] e_frm;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Reference CCITT: XOR the whole word into the register, then shift 16 times.
    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c ^ d;
        for (int i = 0; i < 16; i++) begin
            r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        end
        return r;
    endfunction

    function automatic logic [15:0] hdr_of(input logic [6:0] s);
        return {4'hA, 5'b0, s};
    endfunction

    function automatic vec_t mk(input logic h, input logic v, input logic l, input logic c,
                                input logic [6:0] s, input logic [15:0] d,
                                input logic [15:0] et, input logic [1:0] ek, input logic ev,
                                input logic [15:0] ef, input logic ee);
        vec_t x;
        x.hdr = h; x.valid = v; x.last = l; x.clr = c; x.seq = s; x.din = d;
        x.e_txd = et; x.e_txk = ek; x.e_vld = ev; x.e_frm = ef; x.e_err = ee;
        return x;
    endfunction

    // Quiet cycle whose response is expected to be idle.
    function automatic vec_t quiet(input logic [15:0] ef, input logic ee);
        return mk(0, 0, 0, 0, 7'd0, 16'd0, IDLE_W, 2'b01, 1'b0, ef, ee);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        @(negedge CLK);
        HDR = v.hdr; VALID = v.valid; LAST_WRD = v.last; CLR_CRC = v.clr;
        SEQ = v.seq; DIN = v.din;
        @(posedge CLK);
        #1;
        chk({nm, ".txd"}, {16'd0, TXD}, {16'd0, v.e_txd});
        chk({nm, ".txk"}, {30'd0, TXK}, {30'd0, v.e_txk});
        chk({nm, ".vld"}, {31'd0, TX_VLD}, {31'd0, v.e_vld});
        chk({nm, ".frm"}, {16'd0, FRM_CNT}, {16'd0, v.e_frm});
        chk({nm, ".err"}, {31'd0, PROTO_ERR}, {31'd0, v.e_err});
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        HDR = 0; VALID = 0; LAST_WRD = 0; CLR_CRC = 0; SEQ = '0; DIN = '0;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("reset.txd", {16'd0, TXD}, {16'd0, IDLE_W});
        chk("reset.txk", {30'd0, TXK}, 32'd1);
        chk("reset.vld", {31'd0, TX_VLD}, 32'd0);
        chk("reset.frm", {16'd0, FRM_CNT}, 32'd0);
        chk("reset.err", {31'd0, PROTO_ERR}, 32'd0);
    endtask

    initial begin
        logic [15:0] crc;
        logic [15:0] nominal_crc;

        // ---------------- vector table ----------------
        // nominal frame: seq 5, words 0..7
        crc = crc_ref(INIT_W, 16'hA005);
        vecs.push_back(mk(1, 0, 0, 1, 7'd5, 16'd0, 16'hA005, 2'b00, 1, 16'd0, 0));
        for (int k = 0; k < 8; k++) begin
            crc = crc_ref(crc, 16'(k));
            vecs.push_back(mk(0, 1, k == 7, 0, 7'd0, 16'(k), 16'(k), 2'b00, 1, 16'd0, 0));
        end
        nominal_crc = crc;
        vecs.push_back(mk(0, 0, 0, 0, 7'd0, 16'd0, nominal_crc, 2'b00, 1, 16'd1, 0));
        vecs.push_back(quiet(16'd1, 0));

        // gapped frame: 3 quiet cycles after word 4, same CRC as nominal
        vecs.push_back(mk(1, 0, 0, 1, 7'd5, 16'd0, 16'hA005, 2'b00, 1, 16'd1, 0));
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mk(0, 1, k == 7, 0, 7'd0, 16'(k), 16'(k), 2'b00, 1, 16'd1, 0));
            if (k == 3) begin
                for (int g = 0; g < 3; g++) vecs.push_back(quiet(16'd1, 0));
            end
        end
        vecs.push_back(mk(0, 0, 0, 0, 7'd0, 16'd0, nominal_crc, 2'b00, 1, 16'd2, 0));
        vecs.push_back(quiet(16'd2, 0));

        // back-to-back minimum frames: header two cycles after LAST_WRD
        crc = crc_ref(crc_ref(INIT_W, hdr_of(7'd1)), 16'hBEEF);
        vecs.push_back(mk(1, 0, 0, 1, 7'd1, 16'd0, hdr_of(7'd1), 2'b00, 1, 16'd2, 0));
        vecs.push_back(mk(0, 1, 1, 0, 7'd0, 16'hBEEF, 16'hBEEF, 2'b00, 1, 16'd2, 0));
        vecs.push_back(mk(0, 0, 0, 0, 7'd0, 16'd0, crc, 2'b00, 1, 16'd3, 0));
        crc = crc_ref(crc_ref(INIT_W, hdr_of(7'h7F)), 16'h1234);
        vecs.push_back(mk(1, 0, 0, 1, 7'h7F, 16'd0, 16'hA07F, 2'b00, 1, 16'd3, 0));
        vecs.push_back(mk(0, 1, 1, 0, 7'd0, 16'h1234, 16'h1234, 2'b00, 1, 16'd3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 7'd0, 16'd0, crc, 2'b00, 1, 16'd4, 0));

        // no CLR_CRC: CRC continues from the previous frame's value
        crc = crc_ref(crc_ref(crc, 16'hA000), 16'h5555);
        vecs.push_back(mk(1, 0, 0, 0, 7'd0, 16'd0, 16'hA000, 2'b00, 1, 16'd4, 0));
        vecs.push_back(mk(0, 1, 1, 0, 7'd0, 16'h5555, 16'h5555, 2'b00, 1, 16'd4, 0));
        vecs.push_back(mk(0, 0, 0, 0, 7'd0, 16'd0, crc, 2'b00, 1, 16'd5, 0));
        vecs.push_back(quiet(16'd5, 0));

        // ---------------- run table ----------------
        do_reset();
        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // VALID in IDLE: dropped, flagged, sticky
        do_reset();
        apply(mk(0, 1, 0, 0, 7'd0, 16'h1234, IDLE_W, 2'b01, 0, 16'd0, 1), "vidle.drop");
        apply(quiet(16'd0, 1), "vidle.sticky");
        apply(mk(1, 0, 0, 1, 7'd4, 16'd0, 16'hA004, 2'b00, 1, 16'd0, 1), "vidle.hdr");

        // HDR during BODY: dropped, frame completes with first header's CRC
        do_reset();
        crc = crc_ref(crc_ref(crc_ref(INIT_W, 16'hA003), 16'h1111), 16'h2222);
        apply(mk(1, 0, 0, 1, 7'd3, 16'd0, 16'hA003, 2'b00, 1, 16'd0, 0), "hbody.hdr");
        apply(mk(0, 1, 0, 0, 7'd0, 16'h1111, 16'h1111, 2'b00, 1, 16'd0, 0), "hbody.w0");
        apply(mk(1, 0, 0, 0, 7'd9, 16'd0, IDLE_W, 2'b01, 0, 16'd0, 1), "hbody.nest");
        apply(mk(0, 1, 1, 0, 7'd0, 16'h2222, 16'h2222, 2'b00, 1, 16'd0, 1), "hbody.w1");
        apply(mk(0, 0, 0, 0, 7'd0, 16'd0, crc, 2'b00, 1, 16'd1, 1), "hbody.crc");
        apply(quiet(16'd1, 1), "hbody.idle");

        // reset mid-frame after data word 3: no CRC, FRM_CNT stays 0
        do_reset();
        apply(mk(1, 0, 0, 1, 7'd6, 16'd0, 16'hA006, 2'b00, 1, 16'd0, 0), "mrst.hdr");
        for (int k = 1; k <= 3; k++) begin
            apply(mk(0, 1, 0, 0, 7'd0, 16'(k), 16'(k), 2'b00, 1, 16'd0, 0), $sformatf("mrst.w%0d", k));
        end
        @(negedge CLK);
        RST_N = 1'b0;
        HDR = 0; VALID = 0; LAST_WRD = 0; CLR_CRC = 0; DIN = '0;
        @(posedge CLK);
        #1;
        chk("mrst.txd", {16'd0, TXD}, {16'd0, IDLE_W});
        chk("mrst.vld", {31'd0, TX_VLD}, 32'd0);
        chk("mrst.frm", {16'd0, FRM_CNT}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < 3; k++) apply(quiet(16'd0, 0), $sformatf("mrst.after%0d", k));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
